// File: rtl/vc_dest_router.sv
// Pops words from two virtual-channel FIFOs and routes each one, by one bit of the word,
// to destination FIFO d0 or d1. Define VC_ROUND_ROBIN_EN for alternating VC priority.
module vc_dest_router #(
  parameter int DATA_SIZE = 6,
  parameter int DEST_BIT  = 4,
  parameter int CNT_SIZE  = 5
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic                 vc0_empty,
  input  logic                 vc1_empty,
  input  logic [DATA_SIZE-1:0] vc0_data,
  input  logic [DATA_SIZE-1:0] vc1_data,
  input  logic                 pause_d0,
  input  logic                 pause_d1,
  output logic                 vc0_pop,
  output logic                 vc1_pop,
  output logic                 push_d0,
  output logic                 push_d1,
  output logic [DATA_SIZE-1:0] data_d0,
  output logic [DATA_SIZE-1:0] data_d1,
  output logic                 idle,
  output logic [CNT_SIZE-1:0]  cnt_d0,
  output logic [CNT_SIZE-1:0]  cnt_d1
);

  typedef enum logic [1:0] {
    ST_RESET,
    ST_IDLE,
    ST_ACTIVE
  } state_t;

  localparam logic [CNT_SIZE-1:0] CNT_ONE = CNT_SIZE'(1);

  state_t                 state;
  state_t                 state_nxt;
  logic                   pop_ok;
  logic                   pop_any;
  logic                   s1_valid;
  logic                   s1_src;
  logic [DATA_SIZE-1:0]   word;
  logic                   word_dest;
  logic                   route_d0;
  logic                   route_d1;
  logic                   idle_nxt;

`ifdef VC_ROUND_ROBIN_EN
  // 1 = VC1 was served last, so VC0 wins the next contended cycle
  logic                   last_grant;
`endif

  // Destination is unknown until the word returns, so either pause blocks every pop
  always_comb begin
    pop_ok  = (state != ST_RESET) && !pause_d0 && !pause_d1;
    vc0_pop = 1'b0;
    vc1_pop = 1'b0;
`ifdef VC_ROUND_ROBIN_EN
    if (pop_ok) begin
      if (!vc0_empty && !vc1_empty) begin
        if (last_grant) vc0_pop = 1'b1;
        else            vc1_pop = 1'b1;
      end else if (!vc0_empty) begin
        vc0_pop = 1'b1;
      end else if (!vc1_empty) begin
        vc1_pop = 1'b1;
      end
    end
`else
    if (pop_ok) begin
      if (!vc0_empty)      vc0_pop = 1'b1;
      else if (!vc1_empty) vc1_pop = 1'b1;
    end
`endif
  end

  assign pop_any = vc0_pop | vc1_pop;

  // Read data from the VC popped in the previous cycle is valid now
  always_comb begin
    word      = s1_src ? vc1_data : vc0_data;
    word_dest = word[DEST_BIT];
    route_d0  = s1_valid && (state != ST_RESET) && !word_dest;
    route_d1  = s1_valid && (state != ST_RESET) &&  word_dest;
    idle_nxt  = !pop_any && !s1_valid && vc0_empty && vc1_empty;
  end

  always_comb begin
    state_nxt = state;
    case (state)
      ST_RESET:  state_nxt = ST_IDLE;
      ST_IDLE:   if (pop_any) state_nxt = ST_ACTIVE;
      ST_ACTIVE: if (vc0_empty && vc1_empty && !pop_any && !s1_valid &&
                     !push_d0 && !push_d1)
                   state_nxt = ST_IDLE;
      default:   state_nxt = ST_RESET;
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state    <= ST_RESET;
      s1_valid <= 1'b0;
      s1_src   <= 1'b0;
      push_d0  <= 1'b0;
      push_d1  <= 1'b0;
      data_d0  <= '0;
      data_d1  <= '0;
      cnt_d0   <= '0;
      cnt_d1   <= '0;
      idle     <= 1'b1;
    end else begin
      state    <= state_nxt;
      s1_valid <= pop_any;
      s1_src   <= vc1_pop;
      push_d0  <= route_d0;
      push_d1  <= route_d1;
      idle     <= idle_nxt;
      // Counters advance with the push register so they include the word being pushed
      if (route_d0) begin
        data_d0 <= word;
        cnt_d0  <= cnt_d0 + CNT_ONE;
      end
      if (route_d1) begin
        data_d1 <= word;
        cnt_d1  <= cnt_d1 + CNT_ONE;
      end
    end
  end

`ifdef VC_ROUND_ROBIN_EN
  always_ff @(posedge clk or posedge reset) begin
    if (reset)        last_grant <= 1'b1;
    else if (pop_any) last_grant <= vc1_pop;
  end
`endif

endmodule

// File: tb/tb_vc_dest_router.sv
// Self-checking bench for vc_dest_router: VC FIFO models, a per-destination scoreboard
// checking data and two-cycle latency, a pop-eligibility table and corner-case sequences.
module tb_vc_dest_router;

  logic       clk = 1'b0;
  logic       reset;
  logic       vc0_empty, vc1_empty;
  logic [5:0] vc0_data = '0, vc1_data = '0;
  logic       pause_d0, pause_d1;
  logic       vc0_pop, vc1_pop, push_d0, push_d1, idle;
  logic [5:0] data_d0, data_d1;
  logic [4:0] cnt_d0, cnt_d1;

  always #5 clk = ~clk;

  vc_dest_router #(.DATA_SIZE(6), .DEST_BIT(4), .CNT_SIZE(5)) dut (
    .clk(clk), .reset(reset),
    .vc0_empty(vc0_empty), .vc1_empty(vc1_empty),
    .vc0_data(vc0_data), .vc1_data(vc1_data),
    .pause_d0(pause_d0), .pause_d1(pause_d1),
    .vc0_pop(vc0_pop), .vc1_pop(vc1_pop),
    .push_d0(push_d0), .push_d1(push_d1),
    .data_d0(data_d0), .data_d1(data_d1),
    .idle(idle), .cnt_d0(cnt_d0), .cnt_d1(cnt_d1)
  );

  // VC FIFO models: read data appears the cycle after the pop
  logic [5:0] vc0_mem [0:511];
  logic [5:0] vc1_mem [0:511];
  logic [8:0] vc0_wr = '0, vc1_wr = '0;
  logic [8:0] vc0_rd = '0, vc1_rd = '0;
  assign vc0_empty = (vc0_rd == vc0_wr);
  assign vc1_empty = (vc1_rd == vc1_wr);

  always @(posedge clk) begin
    if (vc0_pop) begin vc0_data <= vc0_mem[vc0_rd]; vc0_rd <= vc0_rd + 9'd1; end
    if (vc1_pop) begin vc1_data <= vc1_mem[vc1_rd]; vc1_rd <= vc1_rd + 9'd1; end
  end

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  int vectors = 0;
  int miscompares = 0;

  task automatic chk(input string name, input logic [31:0] got, input logic [31:0] exp);
    vectors++;
    if (got !== exp) begin
      miscompares++;
      $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, got, exp, cyc);
    end
  endtask

  // Scoreboard
  typedef struct { logic [5:0] data; int due; } exp_t;
  exp_t q0[$];
  exp_t q1[$];
  int   mcnt0 = 0, mcnt1 = 0;
  logic last_model = 1'b1;
  int   src_log[$];

  task automatic enqueue(input logic [5:0] w);
    exp_t e;
    e.data = w;
    e.due  = cyc + 2;
    if (w[4]) begin q1.push_back(e); mcnt1++; end
    else      begin q0.push_back(e); mcnt0++; end
  endtask

  always @(negedge clk) begin
    exp_t e;
    if (reset) begin
      q0.delete(); q1.delete();
      mcnt0 = 0; mcnt1 = 0; last_model = 1'b1;
    end else begin
      if (vc0_pop || vc1_pop) begin
        chk("pop_onehot", {31'd0, vc0_pop & vc1_pop}, 0);
        chk("pop_while_paused", {31'd0, pause_d0 | pause_d1}, 0);
      end
      if (vc0_pop) begin
        chk("pop_empty_vc0", {31'd0, vc0_empty}, 0);
        enqueue(vc0_mem[vc0_rd]); src_log.push_back(0); last_model = 1'b0;
      end else if (vc1_pop) begin
        chk("pop_empty_vc1", {31'd0, vc1_empty}, 0);
        enqueue(vc1_mem[vc1_rd]); src_log.push_back(1); last_model = 1'b1;
      end
      if (push_d0 || push_d1) chk("push_onehot", {31'd0, push_d0 & push_d1}, 0);
      if (push_d0) begin
        if (q0.size() == 0) chk("push_d0_unexpected", 1, 0);
        else begin
          e = q0.pop_front();
          chk("push_d0_data", {26'd0, data_d0}, {26'd0, e.data});
          chk("push_d0_cycle", cyc, e.due);
        end
      end
      if (push_d1) begin
        if (q1.size() == 0) chk("push_d1_unexpected", 1, 0);
        else begin
          e = q1.pop_front();
          chk("push_d1_data", {26'd0, data_d1}, {26'd0, e.data});
          chk("push_d1_cycle", cyc, e.due);
        end
      end
    end
  end

  task automatic step(input int n);
    repeat (n) begin @(posedge clk); #1; end
  endtask

  task automatic load0(input logic [5:0] w);
    vc0_mem[vc0_wr] = w; vc0_wr = vc0_wr + 9'd1;
  endtask

  task automatic load1(input logic [5:0] w);
    vc1_mem[vc1_wr] = w; vc1_wr = vc1_wr + 9'd1;
  endtask

  task automatic drain(input string name);
    int k = 0;
    step(3);
    while (!(idle && vc0_empty && vc1_empty) && k < 200) begin step(1); k++; end
    chk({name, "_drain_timeout"}, {31'd0, k >= 200}, 0);
  endtask

  task automatic do_reset();
    reset = 1'b1; step(2); reset = 1'b0; step(2);
  endtask

  typedef struct {
    string name;
    int    n0, n1;
    logic  p0, p1;
    int    exp;   // 0 none, 1 vc0, 2 vc1, 3 arbitrated
  } vec_t;
  vec_t tbl[8];

  initial begin
    #200000;
    $display("FAIL global_timeout: simulation did not finish");
    $fatal(1, "timeout");
  end

  initial begin
    int pc, pushes, e;
    int ord[6];
    logic [4:0] prev0, prev1;

    tbl[0] = '{"elig_none",      0, 0, 1'b0, 1'b0, 0};
    tbl[1] = '{"elig_vc0",       1, 0, 1'b0, 1'b0, 1};
    tbl[2] = '{"elig_vc1",       0, 1, 1'b0, 1'b0, 2};
    tbl[3] = '{"elig_both",      1, 1, 1'b0, 1'b0, 3};
    tbl[4] = '{"elig_pause0",    1, 0, 1'b1, 1'b0, 0};
    tbl[5] = '{"elig_pause1",    0, 1, 1'b0, 1'b1, 0};
    tbl[6] = '{"elig_pause_all", 1, 1, 1'b1, 1'b1, 0};
    tbl[7] = '{"elig_vc1_p0",    0, 1, 1'b1, 1'b0, 0};
`ifdef VC_ROUND_ROBIN_EN
    ord = '{0, 1, 0, 1, 0, 1};
`else
    ord = '{0, 0, 0, 1, 1, 1};
`endif

    // Reset, then idle with both VCs empty
    reset = 1'b1; pause_d0 = 1'b0; pause_d1 = 1'b0;
    step(3);
    @(negedge clk);
    chk("reset_outputs", {vc0_pop, vc1_pop, push_d0, push_d1, data_d0, data_d1, cnt_d0, cnt_d1, idle}, 1);
    @(posedge clk); #1; reset = 1'b0;
    for (int i = 0; i < 10; i++) begin
      @(negedge clk);
      chk("idle_after_reset", {vc0_pop, vc1_pop, push_d0, push_d1, data_d0, data_d1, cnt_d0, cnt_d1, idle}, 1);
    end
    @(posedge clk); #1;

    // Pop eligibility table
    for (int i = 0; i < 8; i++) begin
      pause_d0 = tbl[i].p0; pause_d1 = tbl[i].p1;
      for (int j = 0; j < tbl[i].n0; j++) load0(6'($urandom_range(0, 63)));
      for (int j = 0; j < tbl[i].n1; j++) load1(6'($urandom_range(0, 63)));
      e = tbl[i].exp;
`ifdef VC_ROUND_ROBIN_EN
      if (e == 3) e = last_model ? 1 : 2;
`else
      if (e == 3) e = 1;
`endif
      @(negedge clk);
      chk(tbl[i].name, {30'd0, vc1_pop, vc0_pop}, e);
      @(posedge clk); #1;
      pause_d0 = 1'b0; pause_d1 = 1'b0;
      drain(tbl[i].name);
    end

    // Single route to d1
    prev0 = 5'(mcnt0); prev1 = 5'(mcnt1);
    load0(6'b010011);
    @(negedge clk);
    chk("route_pop", {31'd0, vc0_pop}, 1);
    pc = cyc;
    @(negedge clk);
    chk("route_no_push_early", {30'd0, push_d0, push_d1}, 0);
    @(negedge clk);
    chk("route_cycle", cyc, pc + 2);
    chk("route_push", {30'd0, push_d0, push_d1}, 1);
    chk("route_data", {26'd0, data_d1}, 32'h13);
    @(posedge clk); #1;
    drain("route");
    chk("route_cnt_d1", {27'd0, cnt_d1}, {27'd0, prev1 + 5'd1});
    chk("route_cnt_d0", {27'd0, cnt_d0}, {27'd0, prev0});

    // Priority order with both VCs loaded
    do_reset();
    pause_d1 = 1'b1;
    for (int j = 0; j < 3; j++) begin
      load0(6'($urandom_range(0, 63)));
      load1(6'($urandom_range(0, 63)));
    end
    src_log.delete();
    step(1);
    pause_d1 = 1'b0;
    drain("prio");
    chk("prio_count", src_log.size(), 6);
    for (int i = 0; i < 6; i++)
      if (i < src_log.size()) chk("prio_order", src_log[i], ord[i]);

    // Backpressure during back-to-back pops
    for (int j = 0; j < 6; j++) load0(6'(j) & 6'b101111);
    step(2);
    pause_d0 = 1'b1;
    pushes = 0;
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      chk("bp_no_pop", {30'd0, vc0_pop, vc1_pop}, 0);
      if (push_d0 || push_d1) pushes++;
      @(posedge clk); #1;
    end
    chk("bp_push_count", pushes, 2);
    pause_d0 = 1'b0;
    @(negedge clk);
    chk("bp_resume", {31'd0, vc0_pop}, 1);
    @(posedge clk); #1;
    drain("bp");

    // Counter wrap on d0
    do_reset();
    for (int j = 0; j < 33; j++) load0(6'(j) & 6'b101111);
    drain("wrap");
    chk("wrap_cnt_d0", {27'd0, cnt_d0}, 1);
    chk("wrap_cnt_d1", {27'd0, cnt_d1}, 0);

    // Reset asserted the cycle after a pop
    load0(6'b010101);
    @(negedge clk);
    chk("midrst_pop", {31'd0, vc0_pop}, 1);
    @(posedge clk); #1;
    reset = 1'b1;
    #1;
    chk("midrst_async", {vc0_pop, vc1_pop, push_d0, push_d1, data_d0, data_d1, cnt_d0, cnt_d1, idle}, 1);
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      chk("midrst_no_push", {30'd0, push_d0, push_d1}, 0);
    end
    @(posedge clk); #1;
    reset = 1'b0;
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      chk("midrst_after", {push_d0, push_d1, cnt_d0, cnt_d1, idle}, 1);
    end
    @(posedge clk); #1;

    chk("sb_leftover", q0.size() + q1.size(), 0);
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
